// File: rtl/reg_write_arbiter_if.sv
// Signal bundle between the write requesters / hazard controller and reg_write_arbiter.
// The master side drives requests and the pending check; the slave side is the arbiter.
interface reg_write_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 2
);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic                  A_VALID;
    logic                  A_READY;
    logic [ADDR_WIDTH-1:0] A_REG;
    logic [DATA_WIDTH-1:0] A_DATA;
    logic                  B_VALID;
    logic                  B_READY;
    logic [ADDR_WIDTH-1:0] B_REG;
    logic [DATA_WIDTH-1:0] B_DATA;
    logic                  WRITEENABLE;
    logic [ADDR_WIDTH-1:0] WRITEREG;
    logic [DATA_WIDTH-1:0] WRITEDATA;
    logic [CNT_WIDTH-1:0]  A_COUNT;
    logic [CNT_WIDTH-1:0]  B_COUNT;
    logic [ADDR_WIDTH-1:0] CHKREG;
    logic                  CHK_PENDING;

    modport master (
        output A_VALID, A_REG, A_DATA, B_VALID, B_REG, B_DATA, CHKREG,
        input  A_READY, B_READY, WRITEENABLE, WRITEREG, WRITEDATA, A_COUNT, B_COUNT, CHK_PENDING
    );

    modport slave (
        input  A_VALID, A_REG, A_DATA, B_VALID, B_REG, B_DATA, CHKREG,
        output A_READY, B_READY, WRITEENABLE, WRITEREG, WRITEDATA, A_COUNT, B_COUNT, CHK_PENDING
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-requester write-port arbiter: per-requester FIFOs drained round-robin, one write
// per clock, onto the register file's single write port, with a buffered-write hazard check.
module reg_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    reg_write_arbiter_if.slave  bus
);
    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int CNT_WIDTH   = $clog2(DEPTH + 1);
    localparam int ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

    // Index 0 is requester A, index 1 is requester B.
    logic [ENTRY_WIDTH-1:0] mem_r     [2][DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_r  [2];
    logic [PTR_WIDTH-1:0]   rd_ptr_r  [2];
    logic [CNT_WIDTH-1:0]   count_r   [2];
    prio_t                  prio_r;
    logic                   write_enable_r;
    logic [ADDR_WIDTH-1:0]  write_reg_r;
    logic [DATA_WIDTH-1:0]  write_data_r;

    logic [1:0]             valid_s;
    logic [1:0]             ready_s;
    logic [1:0]             nonempty_s;
    logic [1:0]             push_s;
    logic [1:0]             pop_s;
    logic [ENTRY_WIDTH-1:0] entry_in_s [2];
    logic [ENTRY_WIDTH-1:0] head_s;
    logic [PTR_WIDTH-1:0]   offset_s;
    logic                   pending_s;

    // Handshake and arbitration decisions from pre-edge state.
    always_comb begin
        valid_s       = {bus.B_VALID, bus.A_VALID};
        entry_in_s[0] = {bus.A_REG, bus.A_DATA};
        entry_in_s[1] = {bus.B_REG, bus.B_DATA};
        for (int i = 0; i < 2; i++) begin
            ready_s[i]    = (count_r[i] < FULL_COUNT);
            nonempty_s[i] = (count_r[i] != {CNT_WIDTH{1'b0}});
            push_s[i]     = valid_s[i] & ready_s[i];
        end
        if (nonempty_s == 2'b11) begin
            if (prio_r == PRIO_A) begin
                pop_s = 2'b01;
            end else begin
                pop_s = 2'b10;
            end
        end else begin
            pop_s = nonempty_s;
        end
        head_s = pop_s[1] ? mem_r[1][rd_ptr_r[1]] : mem_r[0][rd_ptr_r[0]];
    end

    // Hazard check: any live FIFO slot or the active output stage targeting CHKREG.
    always_comb begin
        pending_s = write_enable_r & (write_reg_r == bus.CHKREG);
        offset_s  = {PTR_WIDTH{1'b0}};
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                offset_s  = PTR_WIDTH'(k) - rd_ptr_r[i];
                pending_s = pending_s
                          | ((CNT_WIDTH'(offset_s) < count_r[i])
                          & (mem_r[i][k][ENTRY_WIDTH-1:DATA_WIDTH] == bus.CHKREG));
            end
        end
    end

    // FIFO storage, occupancy, round-robin pointer and the registered write port.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    mem_r[i][k] <= {ENTRY_WIDTH{1'b0}};
                end
                wr_ptr_r[i] <= {PTR_WIDTH{1'b0}};
                rd_ptr_r[i] <= {PTR_WIDTH{1'b0}};
                count_r[i]  <= {CNT_WIDTH{1'b0}};
            end
            prio_r         <= PRIO_A;
            write_enable_r <= 1'b0;
            write_reg_r    <= {ADDR_WIDTH{1'b0}};
            write_data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_s[i]) begin
                    mem_r[i][wr_ptr_r[i]] <= entry_in_s[i];
                    wr_ptr_r[i]           <= wr_ptr_r[i] + 1'b1;
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + 1'b1;
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + 1'b1;
                    2'b01:   count_r[i] <= count_r[i] - 1'b1;
                    default: count_r[i] <= count_r[i];
                endcase
            end
            // Priority only rotates when both requesters actually competed.
            if (nonempty_s == 2'b11) begin
                prio_r <= pop_s[0] ? PRIO_B : PRIO_A;
            end
            if (pop_s != 2'b00) begin
                write_enable_r <= 1'b1;
                write_reg_r    <= head_s[ENTRY_WIDTH-1:DATA_WIDTH];
                write_data_r   <= head_s[DATA_WIDTH-1:0];
            end else begin
                write_enable_r <= 1'b0;
            end
        end
    end

    assign bus.A_READY     = ready_s[0];
    assign bus.B_READY     = ready_s[1];
    assign bus.A_COUNT     = count_r[0];
    assign bus.B_COUNT     = count_r[1];
    assign bus.WRITEENABLE = write_enable_r;
    assign bus.WRITEREG    = write_reg_r;
    assign bus.WRITEDATA   = write_data_r;
    assign bus.CHK_PENDING = pending_s;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_reg_write_arbiter;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DP = 2;

    logic CLK;
    logic RESET;
    int   vectors;
    int   miscompares;

    logic [AW+DW-1:0] qa[$];
    logic [AW+DW-1:0] qb[$];
    bit               mp;
    logic             exp_we;
    logic [AW-1:0]    exp_reg;
    logic [DW-1:0]    exp_data;
    int               ia;
    int               ib;
    bit               pa;
    bit               pb;

    reg_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) bus ();

    reg_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic set_a(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        bus.A_VALID = v;
        bus.A_REG   = r;
        bus.A_DATA  = d;
    endtask

    task automatic set_b(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        bus.B_VALID = v;
        bus.B_REG   = r;
        bus.B_DATA  = d;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [AW-1:0] r,
                             input logic [DW-1:0] d);
        check({tag, "_we"},   32'(bus.WRITEENABLE), 32'(we));
        check({tag, "_reg"},  32'(bus.WRITEREG),    32'(r));
        check({tag, "_data"}, 32'(bus.WRITEDATA),   32'(d));
    endtask

    // Reference model: arbitrate on pre-edge queue contents, then append this edge's pushes.
    task automatic model_step(input bit push_a, input bit push_b);
        logic [AW+DW-1:0] head;
        int sel;
        sel  = -1;
        head = '0;
        if (qa.size() > 0 && qb.size() > 0) begin
            sel = mp ? 1 : 0;
            mp  = ~mp;
        end else if (qa.size() > 0) begin
            sel = 0;
        end else if (qb.size() > 0) begin
            sel = 1;
        end
        if (sel == 0) head = qa.pop_front();
        if (sel == 1) head = qb.pop_front();
        if (sel >= 0) begin
            exp_we   = 1'b1;
            exp_reg  = head[AW+DW-1:DW];
            exp_data = head[DW-1:0];
        end else begin
            exp_we = 1'b0;
        end
        if (push_a) qa.push_back({bus.A_REG, bus.A_DATA});
        if (push_b) qb.push_back({bus.B_REG, bus.B_DATA});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RESET       = 1'b0;
        set_a(1'b0, 3'd0, 8'd0);
        set_b(1'b0, 3'd0, 8'd0);
        bus.CHKREG  = 3'd0;
        repeat (2) @(negedge CLK);

        check_out("rst", 1'b0, 3'd0, 8'd0);
        check("rst_a_count", 32'(bus.A_COUNT), 32'd0);
        check("rst_b_count", 32'(bus.B_COUNT), 32'd0);
        check("rst_a_ready", 32'(bus.A_READY), 32'd1);
        check("rst_b_ready", 32'(bus.B_READY), 32'd1);
        RESET = 1'b1;
        cyc();
        check("idle_we", 32'(bus.WRITEENABLE), 32'd0);

        // Single A write and pending-check window.
        set_a(1'b1, 3'd2, 8'd95);
        bus.CHKREG = 3'd2;
        #1;
        check("t2_pend_pre", 32'(bus.CHK_PENDING), 32'd0);
        cyc();
        set_a(1'b0, 3'd0, 8'd0);
        check("t2_a_count", 32'(bus.A_COUNT), 32'd1);
        check("t2_we_buf", 32'(bus.WRITEENABLE), 32'd0);
        check("t2_pend_buf", 32'(bus.CHK_PENDING), 32'd1);
        bus.CHKREG = 3'd3;
        #1;
        check("t2_pend_other", 32'(bus.CHK_PENDING), 32'd0);
        bus.CHKREG = 3'd2;
        cyc();
        check_out("t2_wr", 1'b1, 3'd2, 8'd95);
        check("t2_a_count0", 32'(bus.A_COUNT), 32'd0);
        check("t2_pend_out", 32'(bus.CHK_PENDING), 32'd1);
        cyc();
        check_out("t2_hold", 1'b0, 3'd2, 8'd95);
        check("t2_pend_done", 32'(bus.CHK_PENDING), 32'd0);

        // Same-edge pushes: A wins first, then priority flips to B.
        set_a(1'b1, 3'd1, 8'd28);
        set_b(1'b1, 3'd4, 8'd6);
        cyc();
        set_a(1'b0, 3'd0, 8'd0);
        set_b(1'b0, 3'd0, 8'd0);
        check_out("t3_none", 1'b0, 3'd2, 8'd95);
        cyc();
        check_out("t3_first", 1'b1, 3'd1, 8'd28);
        check("t3_b_count", 32'(bus.B_COUNT), 32'd1);
        cyc();
        check_out("t3_second", 1'b1, 3'd4, 8'd6);
        set_a(1'b1, 3'd5, 8'h11);
        set_b(1'b1, 3'd6, 8'h22);
        cyc();
        set_a(1'b0, 3'd0, 8'd0);
        set_b(1'b0, 3'd0, 8'd0);
        check("t3_gap_we", 32'(bus.WRITEENABLE), 32'd0);
        cyc();
        check_out("t3_rep_first", 1'b1, 3'd6, 8'h22);
        cyc();
        check_out("t3_rep_second", 1'b1, 3'd5, 8'h11);
        cyc();
        check("t3_idle_we", 32'(bus.WRITEENABLE), 32'd0);

        // Continuous contention for 10 cycles, then drain.
        mp       = 1'b0;
        exp_reg  = 3'd5;
        exp_data = 8'h11;
        ia       = 0;
        ib       = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 10) begin
                set_a(1'b1, AW'(ia), 8'hA0 + DW'(ia));
                set_b(1'b1, AW'(ib + 3), 8'hB0 + DW'(ib));
            end else begin
                set_a(1'b0, 3'd0, 8'd0);
                set_b(1'b0, 3'd0, 8'd0);
            end
            pa = bus.A_VALID && (qa.size() < DP);
            pb = bus.B_VALID && (qb.size() < DP);
            check("t4_a_ready", 32'(bus.A_READY), 32'(qa.size() < DP));
            check("t4_b_ready", 32'(bus.B_READY), 32'(qb.size() < DP));
            model_step(pa, pb);
            if (pa) ia++;
            if (pb) ib++;
            cyc();
            check_out("t4_out", exp_we, exp_reg, exp_data);
            check("t4_a_count", 32'(bus.A_COUNT), 32'(qa.size()));
            check("t4_b_count", 32'(bus.B_COUNT), 32'(qb.size()));
        end
        check("t4_a_accepted", 32'(ia), 32'd6);
        check("t4_b_accepted", 32'(ib), 32'd6);

        // Back-to-back B writes to the same register.
        set_b(1'b1, 3'd7, 8'd50);
        cyc();
        set_b(1'b1, 3'd7, 8'd15);
        check("t5_count1", 32'(bus.B_COUNT), 32'd1);
        check("t5_we0", 32'(bus.WRITEENABLE), 32'd0);
        cyc();
        set_b(1'b0, 3'd0, 8'd0);
        check_out("t5_w1", 1'b1, 3'd7, 8'd50);
        check("t5_count2", 32'(bus.B_COUNT), 32'd1);
        cyc();
        check_out("t5_w2", 1'b1, 3'd7, 8'd15);
        check("t5_count3", 32'(bus.B_COUNT), 32'd0);
        cyc();
        check("t5_we_end", 32'(bus.WRITEENABLE), 32'd0);

        // Fill A while B holds priority, then push into full A during a pop.
        set_a(1'b1, 3'd3, 8'h31);
        set_b(1'b1, 3'd4, 8'h41);
        cyc();
        set_a(1'b1, 3'd3, 8'h32);
        set_b(1'b1, 3'd4, 8'h42);
        cyc();
        set_a(1'b1, 3'd3, 8'h33);
        set_b(1'b0, 3'd0, 8'd0);
        check("t6_a_full", 32'(bus.A_COUNT), 32'd2);
        check("t6_a_notready", 32'(bus.A_READY), 32'd0);
        check_out("t6_b_first", 1'b1, 3'd4, 8'h41);
        cyc();
        set_a(1'b0, 3'd0, 8'd0);
        check("t6_a_count", 32'(bus.A_COUNT), 32'(DP - 1));
        check("t6_a_ready", 32'(bus.A_READY), 32'd1);
        check_out("t6_a_pop", 1'b1, 3'd3, 8'h31);
        cyc();
        check_out("t6_b_pop", 1'b1, 3'd4, 8'h42);
        cyc();
        check_out("t6_a_pop2", 1'b1, 3'd3, 8'h32);
        cyc();
        check("t6_refused_we", 32'(bus.WRITEENABLE), 32'd0);
        check("t6_a_empty", 32'(bus.A_COUNT), 32'd0);

        // Asynchronous reset mid-operation with entries buffered and a strobe in flight.
        set_a(1'b1, 3'd1, 8'h55);
        set_b(1'b1, 3'd2, 8'h66);
        cyc();
        set_a(1'b1, 3'd1, 8'h56);
        set_b(1'b1, 3'd2, 8'h67);
        cyc();
        set_a(1'b0, 3'd0, 8'd0);
        set_b(1'b0, 3'd0, 8'd0);
        check_out("t1_pre", 1'b1, 3'd1, 8'h55);
        check("t1_pre_b_count", 32'(bus.B_COUNT), 32'd2);
        #2;
        RESET = 1'b0;
        #1;
        check_out("t1_async", 1'b0, 3'd0, 8'd0);
        check("t1_a_count", 32'(bus.A_COUNT), 32'd0);
        check("t1_b_count", 32'(bus.B_COUNT), 32'd0);
        check("t1_a_ready", 32'(bus.A_READY), 32'd1);
        check("t1_b_ready", 32'(bus.B_READY), 32'd1);
        @(negedge CLK);
        RESET      = 1'b1;
        bus.CHKREG = 3'd1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            check("t1_post_we", 32'(bus.WRITEENABLE), 32'd0);
            check("t1_post_pend", 32'(bus.CHK_PENDING), 32'd0);
        end

        // Priority returns to A after reset.
        set_a(1'b1, 3'd5, 8'h77);
        set_b(1'b1, 3'd6, 8'h88);
        cyc();
        set_a(1'b0, 3'd0, 8'd0);
        set_b(1'b0, 3'd0, 8'd0);
        cyc();
        check_out("t1_prio_a", 1'b1, 3'd5, 8'h77);
        cyc();
        check_out("t1_prio_b", 1'b1, 3'd6, 8'h88);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Shares the register file's single write port (WRITEENABLE/WRITEREG/WRITEDATA) between two write requesters: A (ALU writeback) and B (load/secondary path).
Each requester pushes writes into its own small FIFO through a valid/ready handshake.
The arbiter drains at most one entry per clock onto the register file write port, choosing round-robin when both FIFOs hold entries.
A combinational pending-check port lets the controller detect hazards against writes still buffered or in flight.

Parameters:
DATA_WIDTH, 8, register data width
ADDR_WIDTH, 3, register index width (8 registers)
DEPTH, 2, entries per requester FIFO; power of 2, minimum 2

Ports:
CLK  in  1  system clock, all state updates on posedge
RESET  in  1  asynchronous, active-low reset
A_VALID  in  1  requester A has a write to push
A_READY  out  1  A FIFO can accept; push occurs when A_VALID & A_READY at posedge
A_REG  in  ADDR_WIDTH  target register for A
A_DATA  in  DATA_WIDTH  write data for A
B_VALID  in  1  as A_VALID, requester B
B_READY  out  1  as A_READY, requester B
B_REG  in  ADDR_WIDTH  target register for B
B_DATA  in  DATA_WIDTH  write data for B
WRITEENABLE  out  1  registered; write strobe to register file
WRITEREG  out  ADDR_WIDTH  registered; write address to register file
WRITEDATA  out  DATA_WIDTH  registered; write data to register file
A_COUNT  out  clog2(DEPTH+1)  A FIFO occupancy
B_COUNT  out  clog2(DEPTH+1)  B FIFO occupancy
CHKREG  in  ADDR_WIDTH  register index to check
CHK_PENDING  out  1  combinational; 1 if any buffered entry, or the output stage while WRITEENABLE=1, targets CHKREG

Behaviour:
- Reset (RESET low, takes effect immediately without a clock edge):
  - Both FIFOs empty; A_COUNT=B_COUNT=0; A_READY=B_READY=1.
  - WRITEENABLE=0, WRITEREG=0, WRITEDATA=0; priority pointer PRIO=A.
  - Reset mid-operation discards all buffered writes; an in-flight strobe drops at once.
  - After release, no WRITEENABLE pulse occurs until a new push.
- READY: x_READY = (x_COUNT < DEPTH), derived from registered count only.
  - No same-cycle pass-through when full: a full FIFO stays not-ready even while popping.
- Push: on posedge with x_VALID & x_READY, {x_REG, x_DATA} is appended at the tail.
  - Push and pop of the same FIFO on one edge is legal; count is unchanged.
- Drain, evaluated on every posedge using pre-edge FIFO contents:
  - Neither FIFO non-empty: WRITEENABLE<=0; WRITEREG/WRITEDATA hold their previous values.
  - Exactly one non-empty: pop its head; PRIO is unchanged.
  - Both non-empty: pop the FIFO selected by PRIO, then PRIO<=other requester.
  - On any pop: WRITEENABLE<=1, WRITEREG<=head reg, WRITEDATA<=head data.
- Latency: push at edge n -> earliest pop at edge n+1 -> WRITEENABLE high for exactly one cycle -> register file captures at edge n+2.
- Throughput: one write per cycle in total. Under continuous contention each requester gets exactly 1 write per 2 cycles.
- Ordering: strict FIFO within a requester. Across requesters, order is set by arbitration only; WAW across A/B is the controller's responsibility, using CHK_PENDING.
- All indices 0..2^ADDR_WIDTH-1 are legal targets; no special zero register. Pointers wrap modulo DEPTH.
- Entries being pushed on the current edge are not yet visible to CHK_PENDING.

Test Plan:
1. Assert RESET low mid-cycle with both FIFOs holding entries -> immediately WRITEENABLE=0, counts 0, READY=1; after release, no write strobes occur.
2. A pushes (reg 2, 95) at edge n, idle otherwise -> WRITEENABLE=1, WRITEREG=2, WRITEDATA=95 for the single cycle after edge n+1. CHK_PENDING with CHKREG=2 is 1 from after edge n until WRITEENABLE falls; CHKREG=3 gives 0.
3. Same-edge pushes A(1, 28) and B(4, 6), PRIO=A -> reg1=28 written first, reg4=6 next cycle. Repeat the pair -> B serviced first.
4. A and B push every cycle for 10 cycles -> output alternates A,B,A,B; counts reach 2; READY toggles low/high. Every accepted entry appears exactly once, in FIFO order.
5. B pushes (reg 7, 50), then (reg 7, 15) back to back -> two consecutive strobes on reg 7 with data 50 then 15; count never exceeds 1.
6. A FIFO full, pop and push attempted on the same edge -> push refused (A_READY=0); A_COUNT becomes DEPTH-1; the next cycle A_READY=1.
